// File: rtl/oser_ddr_gen.sv
// Parallel-to-DDR gearbox: splits each WIDTH*RATIO word into RATIO/2 rise/fall pairs per lane for an ODDR.
// Define SERDES_UNDERRUN_EN to add the saturating `underruns` gap counter port.
module oser_ddr_gen #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned RATIO = 4,
  parameter logic        IDLE  = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH*RATIO-1:0]   s_data,
  input  logic [RATIO/2-1:0]       s_oen,
  output logic [WIDTH-1:0]         q_rise,
  output logic [WIDTH-1:0]         q_fall,
  output logic                     q_oen,
  output logic                     busy
`ifdef SERDES_UNDERRUN_EN
  ,
  output logic [15:0]              underruns
`endif
);

  localparam int unsigned PAIRS = RATIO / 2;
  localparam int unsigned CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH*RATIO-1:0] word_q, word_d;
  logic [PAIRS-1:0]       oenw_q, oenw_d;
  logic [WIDTH-1:0]       rise_d, fall_d;
  logic                   qoen_d, busy_d;
  logic                   xfer;
  logic                   emit;
  logic [WIDTH*RATIO-1:0] src_w;
  logic [PAIRS-1:0]       src_o;
  logic [RATIO-1:0]       lane;

  assign s_ready = !reset && ((state_q == ST_IDLE) || (cnt_q == LAST));
  assign xfer    = s_valid && s_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      oenw_q  <= '0;
      q_rise  <= {WIDTH{IDLE}};
      q_fall  <= {WIDTH{IDLE}};
      q_oen   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      oenw_q  <= oenw_d;
      q_rise  <= rise_d;
      q_fall  <= fall_d;
      q_oen   <= qoen_d;
      busy    <= busy_d;
    end
  end

  // Held word is shifted down two bits per lane each pair, so the next pair is always at lane bits [1:0].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    oenw_d  = oenw_q;
    rise_d  = {WIDTH{IDLE}};
    fall_d  = {WIDTH{IDLE}};
    qoen_d  = 1'b1;
    busy_d  = 1'b0;
    emit    = 1'b0;
    src_w   = word_q;
    src_o   = oenw_q;
    lane    = '0;

    if (xfer) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      src_w   = s_data;
      src_o   = s_oen;
      emit    = 1'b1;
    end else if ((state_q == ST_SHIFT) && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
      emit  = 1'b1;
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    if (emit) begin
      for (int unsigned l = 0; l < WIDTH; l++) begin
        lane                          = src_w[l*RATIO +: RATIO];
        rise_d[l]                     = lane[0];
        fall_d[l]                     = lane[1];
        word_d[l*RATIO +: RATIO]      = lane >> 2;
      end
      qoen_d = src_o[0];
      oenw_d = src_o >> 1;
      busy_d = 1'b1;
    end
  end

`ifdef SERDES_UNDERRUN_EN
  logic [15:0] underrun_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      underrun_q <= '0;
    end else if ((state_q == ST_SHIFT) && (state_d == ST_IDLE) && (underrun_q != '1)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underruns = underrun_q;
`endif

endmodule
